decoder_3to8: RTL and testbench
===============================

# decoder_3to8

Registered 3-to-8 one-hot decoder with enable. It converts a 3-bit binary index into an 8-bit one-hot select word, or all zeros when disabled. Its main use is driving column selects for the LED array driver, which scans the Conway cell grid one column at a time and uses the low N bits of the output. The output is registered so the column strobe is glitch-free and aligned to the system clock.

## Interface
- Parameters: none. The input width is fixed at 3 and the output width at 8.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `ena`  input  1  decode enable, active-high.
- `in`  input  3  binary index; bit 2 is the MSB.
- `out`  output  8  one-hot decoded word, registered.

## Operation
- Next-state function, evaluated each cycle:
  - `ena`=1: `out_next[k]` = 1 exactly when k equals unsigned `in`, for k in 0..7.
  - `ena`=0: `out_next` = 8'b0000_0000.
- `out` is driven directly from an 8-bit register, with no combinational path from inputs to output.
- Invariant: `out` is either all zeros or has exactly one bit set. It never has two or more bits set.
- Mapping:
  - `in`=0 gives 8'b0000_0001.
  - `in`=1 gives 8'b0000_0010.
  - Continuing in this pattern, `in`=7 gives 8'b1000_0000.
- No invalid input codes exist; all 8 values of `in` decode.
- X/Z on `in` or `ena` is out of contract. Verification flags it with an assertion when `rst_n`=1.
- Width adaptation belongs to the instantiating block, not to this block:
  - A parent with a wider index connects only bits [2:0].
  - A parent using fewer than 8 selects connects `out[N-1:0]`.
  - If the parent drives an index ≥ N, no used select is active. This is the parent's responsibility.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge t appear on `out` after edge t, and hold until the next edge.
- Reset:
  - `rst_n` low forces `out` = 8'h00 immediately, without waiting for a clock edge.
  - `out` stays 8'h00 while `rst_n` is low.
- Reset release:
  - Release is synchronous in effect: the first capture happens on the first rising edge after `rst_n` goes high.
  - The integrator supplies release synchronised to `clk`. The block itself adds no synchroniser.
- Reset asserted mid-operation: `out` clears within the same cycle. The previous index is not retained.
- Changing `ena` and `in` on the same cycle: the decision uses only the values sampled at the edge. There is no priority issue because `ena`=0 always wins, giving zero.
- Back-to-back index changes each cycle give one new one-hot value per cycle, with no bubble.
- No handshake; the block accepts input every cycle.

## Test plan
- Reset:
  - Drive `rst_n`=0 with `ena`=1, `in`=3, and toggle `clk`; `out` must be 8'h00 throughout.
  - Release `rst_n`; after the first edge, `out` must be 8'h08.
- Exhaustive decode with `ena`=1:
  - Sweep `in` through 0..7, one value per cycle.
  - `out` must follow 01, 02, 04, 08, 10, 20, 40, 80 (hex), each one cycle after its input.
- Disable:
  - With `ena`=0, sweep `in` through 0..7; `out` must stay 8'h00 every cycle.
  - Toggle `ena` 1→0→1 with `in`=5; `out` must be 20, 00, 20 on successive cycles.
- Asynchronous reset mid-run:
  - With `out`=8'h40, pulse `rst_n` low between clock edges; `out` must be 8'h00 before the next edge.
  - After release, with `in`=6 and `ena`=1, `out` must be 8'h40 one edge later.
- One-hot invariant:
  - Apply 1000 random cycles of `ena`/`in`.
  - Assert on every cycle: `$onehot0(out)`, and `out` equals the registered value of `ena ? 1<<in : 0`.
- LED column use with N=5:
  - Drive `in`=4; `out[4:0]` must be 5'b10000.
  - Drive `in`=5..7; `out[4:0]` must be 5'b00000.

Source files
------------

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with enable.
// Drives glitch-free column strobes; all zeros when disabled or in reset.
module decoder_3to8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] in,
    output logic [7:0] out
);

    logic [7:0] out_next;

    always_comb begin
        out_next = 8'h00;
        if (ena) begin
            out_next[in] = 1'b1;
        end
    end

    // Output comes straight from the register so downstream strobes never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 8'h00;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: directed steps plus random cycles
// compared against a power-of-two reference model.
module tb_decoder_3to8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] in;
    logic [7:0] out;

    int n_checks = 0;
    int n_fails  = 0;

    decoder_3to8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .in    (in),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs must be known whenever the block is out of reset.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown({ena, in}))
            else $error("[TB] X/Z on ena/in while out of reset");
        end
    end

    function automatic logic [7:0] model(input logic e, input logic [2:0] idx);
        int unsigned weight;
        weight = 2 ** int'(idx);
        return e ? 8'(weight) : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after a falling edge, let one rising edge capture them,
    // then return at the next falling edge where outputs are sampled.
    task automatic apply_stimulus(input logic e, input logic [2:0] idx);
        ena = e;
        in  = idx;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic       e;
        logic [2:0] idx;
        logic [7:0] expected;

        rst_n = 1'b0;
        ena   = 1'b1;
        in    = 3'd3;

        // Reset held with live inputs: output must stay clear across edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset_hold_%0d", k), out, 8'h00);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_release", out, 8'h08);

        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, 3'(k));
            check($sformatf("decode_in%0d", k), out, model(1'b1, 3'(k)));
        end

        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, 3'(k));
            check($sformatf("disabled_in%0d", k), out, 8'h00);
        end

        apply_stimulus(1'b1, 3'd5);
        check("ena_toggle_1", out, 8'h20);
        apply_stimulus(1'b0, 3'd5);
        check("ena_toggle_0", out, 8'h00);
        apply_stimulus(1'b1, 3'd5);
        check("ena_toggle_1b", out, 8'h20);

        // Reset pulse between edges must clear immediately, not at the next edge.
        apply_stimulus(1'b1, 3'd6);
        check("pre_async_reset", out, 8'h40);
        #1 rst_n = 1'b0;
        #1 check("async_reset_clear", out, 8'h00);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_async_reset", out, 8'h40);

        for (int k = 0; k < 1000; k++) begin
            e   = 1'($urandom_range(0, 1));
            idx = 3'($urandom_range(0, 7));
            expected = model(e, idx);
            apply_stimulus(e, idx);
            check($sformatf("rand_onehot0_%0d", k), {7'b0, $onehot0(out)}, 8'h01);
            check($sformatf("rand_value_%0d", k), out, expected);
        end

        apply_stimulus(1'b1, 3'd4);
        check("col5_in4", {3'b000, out[4:0]}, 8'b0001_0000);
        for (int k = 5; k < 8; k++) begin
            apply_stimulus(1'b1, 3'(k));
            check($sformatf("col5_in%0d", k), {3'b000, out[4:0]}, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
